// File: rtl/reflet_float_unit_arbiter.sv
// Shares one multi-cycle floating-point unit between two requesters.
// Round-robin grant, operand latch, fixed-latency hold, one-cycle ack.
module reflet_float_unit_arbiter #(
    parameter int float_size = 16,
    parameter int op_size    = 2,
    parameter int latency    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [op_size-1:0]    op0,
    input  logic [float_size-1:0] a0,
    input  logic [float_size-1:0] b0,
    output logic                  ack0,
    output logic [float_size-1:0] res0,
    input  logic                  req1,
    input  logic [op_size-1:0]    op1,
    input  logic [float_size-1:0] a1,
    input  logic [float_size-1:0] b1,
    output logic                  ack1,
    output logic [float_size-1:0] res1,
    output logic [op_size-1:0]    unit_op,
    output logic [float_size-1:0] unit_a,
    output logic [float_size-1:0] unit_b,
    input  logic [float_size-1:0] unit_result,
    output logic                  busy
);

    localparam int cnt_w = (latency > 1) ? $clog2(latency + 1) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(latency - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] counter;
    logic             grant;
    logic             last_grant;
    logic             do_grant;
    logic             pick;

    // Next-state logic and round-robin choice among pending requests.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        pick       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    do_grant = 1'b1;
                    pick     = ~last_grant;
                end else if (req0) begin
                    do_grant = 1'b1;
                    pick     = 1'b0;
                end else if (req1) begin
                    do_grant = 1'b1;
                    pick     = 1'b1;
                end
                if (do_grant) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (counter == last_cnt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand latch, latency counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            unit_op    <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            res0       <= '0;
            res1       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        grant      <= pick;
                        last_grant <= pick;
                        counter    <= '0;
                        unit_op    <= pick ? op1 : op0;
                        unit_a     <= pick ? a1 : a0;
                        unit_b     <= pick ? b1 : b0;
                    end
                end
                HOLD: begin
                    if (counter == last_cnt) begin
                        if (grant) begin
                            res1 <= unit_result;
                        end else begin
                            res0 <= unit_result;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ack0 = (state == DONE) && !grant;
    assign ack1 = (state == DONE) && grant;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reflet_float_unit_arbiter.sv
// Bench for reflet_float_unit_arbiter: directed handshake cases,
// latency 1/5 builds and randomized traffic against a timing model.
module tb_reflet_float_unit_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, busy;
    logic [15:0] res0, res1;
    logic [1:0]  unit_op;
    logic [15:0] unit_a, unit_b, unit_result;

    logic        rq_1, rq_5;
    logic [15:0] la, lb;
    logic        ack0_1, ack1_1, busy_1, ack0_5, ack1_5, busy_5;
    logic [15:0] res0_1, res1_1, ua_1, ub_1, ur_1;
    logic [15:0] res0_5, res1_5, ua_5, ub_5, ur_5;
    logic [1:0]  uo_1, uo_5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Simplified fp16 multiply for normal numbers, truncating.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], 5'(e), m};
    endfunction

    function automatic logic [15:0] unit_model(input logic [1:0] op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        case (op)
            2'd0:    return fmul(a, b);
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign unit_result = unit_model(unit_op, unit_a, unit_b);
    assign ur_1        = unit_model(uo_1, ua_1, ub_1);
    assign ur_5        = unit_model(uo_5, ua_5, ub_5);

    reflet_float_unit_arbiter #(.float_size(16), .op_size(2), .latency(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .res0(res0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .res1(res1),
        .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_result(unit_result), .busy(busy)
    );

    reflet_float_unit_arbiter #(.float_size(16), .op_size(2), .latency(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req0(rq_1), .op0(2'd0), .a0(la), .b0(lb), .ack0(ack0_1), .res0(res0_1),
        .req1(1'b0), .op1(2'd0), .a1(16'h0), .b1(16'h0), .ack1(ack1_1), .res1(res1_1),
        .unit_op(uo_1), .unit_a(ua_1), .unit_b(ub_1),
        .unit_result(ur_1), .busy(busy_1)
    );

    reflet_float_unit_arbiter #(.float_size(16), .op_size(2), .latency(5)) dut_l5 (
        .clk(clk), .reset(reset),
        .req0(rq_5), .op0(2'd0), .a0(la), .b0(lb), .ack0(ack0_5), .res0(res0_5),
        .req1(1'b0), .op1(2'd0), .a1(16'h0), .b1(16'h0), .ack1(ack1_5), .res1(res1_5),
        .unit_op(uo_5), .unit_a(ua_5), .unit_b(ub_5),
        .unit_result(ur_5), .busy(busy_5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic rq, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin
            req0 = rq; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = rq; op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rq_1 = 1'b0; rq_5 = 1'b0;
        step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_res0", res0, 0);
        check("rst_res1", res1, 0);
        check("rst_ua", unit_a, 0);
        check("rst_ub", unit_b, 0);
        check("rst_uop", unit_op, 0);
    endtask

    int          t0, t1, f1, f5, nb1, nb5, na1, na5;
    int          ack_cyc[$];
    int          ack_who[$];
    int          g, owner, free_at;
    logic        mlast, e_done, pk;
    logic [1:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [15:0] mres[2];
    int          rs[2];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rq_1 = 1'b0; rq_5 = 1'b0; la = '0; lb = '0;
        do_reset();

        // single request
        drive(0, 1'b1, 2'd0, 16'h3C00, 16'h4000);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("s_busy%0d", c), busy, (c <= 3));
            check($sformatf("s_ack0_%0d", c), ack0, (c == 3));
            check($sformatf("s_ack1_%0d", c), ack1, 0);
            check($sformatf("s_ua%0d", c), unit_a, 16'h3C00);
            if (c == 3) begin
                check("s_res0", res0, 16'h4000);
                req0 = 1'b0;
            end
        end

        // first contention after reset
        do_reset();
        drive(0, 1'b1, 2'd0, 16'h3C00, 16'h4000);
        drive(1, 1'b1, 2'd0, 16'h4000, 16'h4000);
        t0 = -1; t1 = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (ack0) begin t0 = c; req0 = 1'b0; end
            if (ack1) begin t1 = c; req1 = 1'b0; end
        end
        check("cont_t0", t0, 3);
        check("cont_t1", t1, 7);
        check("cont_res0", res0, 16'h4000);
        check("cont_res1", res1, 16'h4400);

        // fairness with both requests held
        drive(0, 1'b1, 2'd1, 16'h0011, 16'h0022);
        drive(1, 1'b1, 2'd3, 16'h00F0, 16'h000F);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) step();
            if (ack0 || ack1) begin
                ack_cyc.push_back(c);
                ack_who.push_back(int'(ack1));
            end
            if (c == 23) begin req0 = 1'b0; req1 = 1'b0; end
        end
        check("fair_n", ack_cyc.size(), 6);
        for (int i = 0; i < ack_cyc.size() && i < 6; i++) begin
            check($sformatf("fair_cyc%0d", i), ack_cyc[i], 3 + 4 * i);
            check($sformatf("fair_who%0d", i), ack_who[i], i % 2);
        end
        check("fair_res0", res0, 16'h0033);
        check("fair_res1", res1, 16'h00FF);

        // operand stability during HOLD
        step();
        drive(0, 1'b1, 2'd0, 16'h3C00, 16'h4000);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) a0 = 16'h7BFF;
            check($sformatf("stab_ua%0d", c), unit_a, 16'h3C00);
            check($sformatf("stab_ack%0d", c), ack0, (c == 3));
        end
        check("stab_res0", res0, 16'h4000);
        req0 = 1'b0;
        step();

        // reset in the first HOLD cycle
        drive(0, 1'b1, 2'd0, 16'h4000, 16'h4000);
        step();
        check("rh_busy1", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rh_busy", busy, 0);
        check("rh_ack0", ack0, 0);
        check("rh_ua", unit_a, 0);
        check("rh_ub", unit_b, 0);
        check("rh_uop", unit_op, 0);
        check("rh_res0", res0, 0);
        check("rh_res1", res1, 0);
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("rh_ack_%0d", c), ack0, (c == 3));
        end
        check("rh_res0_new", res0, 16'h4400);
        req0 = 1'b0;
        step();

        // latency 1 and 5 builds
        la = 16'h3C00; lb = 16'h4000;
        rq_1 = 1'b1; rq_5 = 1'b1;
        f1 = -1; f5 = -1; nb1 = 0; nb5 = 0; na1 = 0; na5 = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (busy_1) nb1++;
            if (busy_5) nb5++;
            if (ack0_1) begin na1++; if (f1 < 0) f1 = c; rq_1 = 1'b0; end
            if (ack0_5) begin na5++; if (f5 < 0) f5 = c; rq_5 = 1'b0; end
        end
        check("l1_ack_cyc", f1, 2);
        check("l5_ack_cyc", f5, 6);
        check("l1_acks", na1, 1);
        check("l5_acks", na5, 1);
        check("l1_busy", nb1, 2);
        check("l5_busy", nb5, 6);
        check("l1_res", res0_1, 16'h4000);
        check("l5_res", res0_5, 16'h4000);

        // randomized traffic against a transaction timing model
        do_reset();
        g = -100; owner = 0; free_at = 0; mlast = 1'b1;
        m_op = '0; m_a = '0; m_b = '0;
        mres[0] = '0; mres[1] = '0;
        rs[0] = 0; rs[1] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) step();
            e_done = (cyc == g + LAT + 1);
            if (e_done) mres[owner] = unit_model(m_op, m_a, m_b);
            check("r_busy", busy, (cyc > g) && (cyc <= g + LAT + 1));
            check("r_ack0", ack0, e_done && owner == 0);
            check("r_ack1", ack1, e_done && owner == 1);
            check("r_uop", unit_op, m_op);
            check("r_ua", unit_a, m_a);
            check("r_ub", unit_b, m_b);
            check("r_res0", res0, mres[0]);
            check("r_res1", res1, mres[1]);
            for (int r = 0; r < 2; r++) begin
                if (e_done && owner == r) rs[r] = 0;
                if (rs[r] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rs[r] = 1;
                        drive(r, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom));
                    end else begin
                        drive(r, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
                    end
                end else if (rs[r] == 2) begin
                    if ($urandom_range(0, 3) == 0) begin
                        drive(r, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
                    end
                end
            end
            if (cyc >= free_at && (req0 || req1)) begin
                pk = (req0 && req1) ? ~mlast : req1;
                owner = int'(pk);
                mlast = pk;
                g = cyc;
                free_at = cyc + LAT + 2;
                m_op = pk ? op1 : op0;
                m_a = pk ? a1 : a0;
                m_b = pk ? b1 : b0;
                rs[owner] = 2;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/reflet_float_unit_arbiter.md
Name: reflet_float_unit_arbiter

Overview:
- Shares one multi-cycle floating-point operation unit between two requesters. Examples of such a unit are the multiplier and the adder/subtractor, which need a fixed number of cycles with stable inputs.
- Replaces the "watch the inputs until they stay stable" readiness scheme with an explicit req/ack handshake and a latency counter started at issue.
- Sits between the FPU front-end ports (for example, the CPU side and a DMA or second-core side) and the shared arithmetic datapath.

Parameters:
- float_size, 16, width of operands and result in bits.
- op_size, 2, width of the opcode forwarded to the shared unit.
- latency, 2, number of cycles the unit inputs must be held stable before the result is valid. Must be >= 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 operation request, level-held until ack0.
- op0  input  op_size  requester 0 opcode.
- a0  input  float_size  requester 0 operand A.
- b0  input  float_size  requester 0 operand B.
- ack0  output  1  one-cycle pulse: res0 is valid and the operation is complete.
- res0  output  float_size  requester 0 result, held until requester 0's next completion.
- req1, op1, a1, b1, ack1, res1  same as the requester 0 ports, for requester 1.
- unit_op  output  op_size  opcode driven to the shared unit.
- unit_a  output  float_size  operand A driven to the shared unit.
- unit_b  output  float_size  operand B driven to the shared unit.
- unit_result  input  float_size  result from the shared unit, treated as combinational from unit_op/a/b.
- busy  output  1  high while an operation is in flight (HOLD or DONE state).

Behaviour:
- All registers update on posedge clk. reset has priority over everything else.
- Values forced by reset:
  - state = IDLE
  - ack0 = ack1 = 0, res0 = res1 = 0
  - unit_op = unit_a = unit_b = 0
  - busy = 0, counter = 0
  - last_grant = 1, so requester 0 wins the first contention.
- State IDLE:
  - req sampled only in this state.
  - No req high: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester not equal to last_grant (round-robin).
  - On a grant, latch the granted op/a/b into unit_op/unit_a/unit_b, record the granted index, set last_grant to it, clear counter, go to HOLD.
- State HOLD:
  - unit_op/a/b stay at the latched values; requester operand changes are ignored.
  - counter increments each cycle.
  - When counter == latency-1, capture unit_result into the granted requester's res register and go to DONE.
  - HOLD therefore lasts exactly latency cycles.
- State DONE (one cycle):
  - The granted requester's ack is high; the other ack stays 0.
  - Next state is IDLE.
  - The non-granted res register is never modified.
- Timing:
  - req seen high in IDLE at cycle N gives unit inputs valid from cycle N+1.
  - ack is high in cycle N+latency+1.
  - The next grant can occur at cycle N+latency+2.
  - Throughput is one operation per latency+2 cycles.
- Handshake rules:
  - The requester keeps req and its operands until it sees ack.
  - A requester whose req is still high in the IDLE cycle after DONE starts a new operation. This is legal back-to-back use.
  - Dropping req after a grant does not cancel the operation; ack still pulses.
- busy = (state != IDLE).
- counter width is $clog2(latency+1). It never exceeds latency-1.
- Reset mid-operation:
  - The operation in flight is abandoned and no ack is issued.
  - All outputs return to their reset values on the next cycle, including both res registers being cleared.
- The opcode is forwarded untouched; the arbiter does no arithmetic on data.

Test Plan:
- Single request. Setup: latency=2, unit model = fp16 multiply. Stimulus: req0=1, a0=16'h3C00, b0=16'h4000 seen in IDLE at cycle 0. Required response: unit_a=16'h3C00 from cycle 1; ack0 high in cycle 3 only; res0=16'h4000; ack1 never high; busy high in cycles 1-3.
- First contention after reset. Stimulus: req0 and req1 rise in the same IDLE cycle. Required response: requester 0 served first (ack0 at +3), then requester 1 granted in the IDLE cycle after DONE (ack1 at +7).
- Fairness. Stimulus: both req held high continuously for 6 operations. Required response: ack order 0,1,0,1,0,1; exactly one ack per 4-cycle slot at latency=2.
- Operand stability. Stimulus: after grant, a0 changes from 16'h3C00 to 16'h7BFF during HOLD. Required response: unit_a stays 16'h3C00 until DONE; res0 reflects 16'h3C00.
- Reset mid-HOLD. Stimulus: assert reset for 1 cycle in the first HOLD cycle. Required response: no ack; the next cycle shows busy=0, unit_a/b/op=0, res0=res1=0; a new req0 afterwards is served normally.
- latency=1 and latency=5 builds. Stimulus: single request in each build. Required response: ack is high exactly latency+1 cycles after the IDLE sample; the counter never reaches latency.
